logic_gate_unit: RTL and testbench

- Parametrised, registered successor to the single-bit combinational gate blocks.
- Evaluates one of eight bitwise gate functions on WIDTH-bit operands per valid/ready transaction and buffers results in a 2-entry output queue.
- Counts how often the delivered output value changes.
- Sits between a stimulus/control source and any consumer that needs backpressure-safe, value-change-aware gate results.

---
 rtl/lgu_pkg.sv | 39 +++
 rtl/logic_gate_unit_if.sv | 28 ++
 rtl/lgu_out_queue.sv | 53 +++++
 rtl/logic_gate_unit.sv | 56 +++++
 tb/tb_logic_gate_unit.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/lgu_pkg.sv
// Shared types and the bitwise gate function for logic_gate_unit.
// Operands are evaluated at MAXW bits and truncated by the caller.
package lgu_pkg;

    typedef enum logic [2:0] {
        OP_NOT  = 3'd0,
        OP_AND  = 3'd1,
        OP_OR   = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XOR  = 3'd5,
        OP_XNOR = 3'd6,
        OP_BUF  = 3'd7
    } op_e;

    localparam int QDEPTH = 2;
    localparam int MAXW   = 64;

    function automatic logic [MAXW-1:0] gate_eval(
        input op_e             op,
        input logic [MAXW-1:0] a,
        input logic [MAXW-1:0] b
    );
        logic [MAXW-1:0] r;
        r = '0;
        unique case (op)
            OP_NOT:  r = ~a;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_NAND: r = ~(a & b);
            OP_NOR:  r = ~(a | b);
            OP_XOR:  r = a ^ b;
            OP_XNOR: r = ~(a ^ b);
            OP_BUF:  r = a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic_gate_unit_if.sv
// Request/result bundle between a gate source, logic_gate_unit and
// the result consumer.
interface logic_gate_unit_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    lgu_pkg::op_e     op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             y_changed;
    logic [CNT_W-1:0] chg_count;
    logic             clear_cnt;

    modport master (
        output in_valid, op, a, b, out_ready, clear_cnt,
        input  in_ready, out_valid, y, y_changed, chg_count
    );

    modport slave (
        input  in_valid, op, a, b, out_ready, clear_cnt,
        output in_ready, out_valid, y, y_changed, chg_count
    );
endinterface

// File: rtl/lgu_out_queue.sv
// Two-entry result FIFO; r_q0 is always the head, so y comes
// straight from a register and keeps its value when empty.
module lgu_out_queue
    import lgu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_head
);
    localparam logic [1:0] FULL = 2'(QDEPTH);

    logic [1:0]       r_cnt;
    logic [WIDTH-1:0] r_q0;
    logic [WIDTH-1:0] r_q1;
    logic             w_push;
    logic             w_pop;

    assign o_ready = (r_cnt != FULL) && rst_n;
    assign o_valid = (r_cnt != 2'd0);
    assign o_head  = r_q0;
    assign w_push  = i_push && o_ready;
    assign w_pop   = i_pop && o_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 2'd0;
            r_q0  <= '0;
            r_q1  <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) r_q0 <= i_data;
                    else               r_q1 <= i_data;
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    if (r_cnt == FULL) r_q0 <= r_q1;
                    r_cnt <= r_cnt - 2'd1;
                end
                // Push implies not full, pop implies not empty: head only
                2'b11: r_q0 <= i_data;
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/logic_gate_unit.sv
// Registered bitwise gate unit with a 2-entry result queue and a
// saturating counter of value changes on delivered results.
module logic_gate_unit
    import lgu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    logic_gate_unit_if.slave   bus
);
    logic [MAXW-1:0]  w_full;
    logic [WIDTH-1:0] w_res;
    logic             w_pop;
    logic             w_diff;
    logic [WIDTH-1:0] r_last_y;
    logic             r_chg;
    logic [CNT_W-1:0] r_cnt;

    assign w_full = gate_eval(bus.op, MAXW'(bus.a), MAXW'(bus.b));
    assign w_res  = w_full[WIDTH-1:0];

    lgu_out_queue #(.WIDTH(WIDTH)) u_q (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (bus.in_valid),
        .i_data  (w_res),
        .i_pop   (bus.out_ready),
        .o_ready (bus.in_ready),
        .o_valid (bus.out_valid),
        .o_head  (bus.y)
    );

    assign w_pop  = bus.out_valid && bus.out_ready;
    assign w_diff = w_pop && (bus.y != r_last_y);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_y <= '0;
            r_chg    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_chg <= w_diff;
            if (w_pop) r_last_y <= bus.y;
            // A clear landing on a change keeps that change
            if (bus.clear_cnt)
                r_cnt <= w_diff ? CNT_W'(1) : '0;
            else if (w_diff && (r_cnt != '1))
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign bus.y_changed = r_chg;
    assign bus.chg_count = r_cnt;
endmodule

// File: tb/tb_logic_gate_unit.sv
// Directed bench for logic_gate_unit (WIDTH=8, CNT_W=2).
module tb_logic_gate_unit;
    import lgu_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic_gate_unit_if #(.WIDTH(8), .CNT_W(2)) bus ();

    logic_gate_unit #(.WIDTH(8), .CNT_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        op_e        op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] y;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic drive(input logic v, input op_e op,
                         input logic [7:0] a);
        bus.in_valid = v;
        bus.op       = op;
        bus.a        = a;
        bus.b        = 8'h00;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op        = OP_NOT;
        bus.a         = 8'h00;
        bus.b         = 8'h00;
        bus.out_ready = 1'b0;
        bus.clear_cnt = 1'b0;

        vecs[0] = '{OP_NOT,  8'hF0, 8'hCC, 8'h0F};
        vecs[1] = '{OP_AND,  8'hF0, 8'hCC, 8'hC0};
        vecs[2] = '{OP_OR,   8'hF0, 8'hCC, 8'hFC};
        vecs[3] = '{OP_NAND, 8'hF0, 8'hCC, 8'h3F};
        vecs[4] = '{OP_NOR,  8'hF0, 8'hCC, 8'h03};
        vecs[5] = '{OP_XOR,  8'hF0, 8'hCC, 8'h3C};
        vecs[6] = '{OP_XNOR, 8'hF0, 8'hCC, 8'hC3};
        vecs[7] = '{OP_BUF,  8'hF0, 8'hCC, 8'hF0};

        // Reset state
        tick();
        tick();
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_y", 32'(bus.y), 0);
        chk("rst_y_changed", 32'(bus.y_changed), 0);
        chk("rst_chg_count", 32'(bus.chg_count), 0);
        rst_n = 1'b1;
        tick();
        chk("rel_in_ready", 32'(bus.in_ready), 1);

        // Opcode sweep, back-to-back
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1;
            bus.op       = vecs[i].op;
            bus.a        = vecs[i].a;
            bus.b        = vecs[i].b;
            chk($sformatf("sweep_rdy%0d", i), 32'(bus.in_ready), 1);
            tick();
            chk($sformatf("sweep_v%0d", i), 32'(bus.out_valid), 1);
            chk($sformatf("sweep_y%0d", i), 32'(bus.y), 32'(vecs[i].y));
        end
        bus.in_valid = 1'b0;
        tick();
        chk("sweep_drain", 32'(bus.out_valid), 0);

        // Backpressure
        do_reset();
        bus.out_ready = 1'b0;
        drive(1'b1, OP_BUF, 8'h11);
        tick();
        drive(1'b1, OP_BUF, 8'h22);
        tick();
        chk("bp_full_ready", 32'(bus.in_ready), 0);
        chk("bp_head0", 32'(bus.y), 32'h11);
        drive(1'b1, OP_BUF, 8'h33);
        tick();
        chk("bp_still_full", 32'(bus.in_ready), 0);
        chk("bp_head_hold", 32'(bus.y), 32'h11);
        bus.out_ready = 1'b1;
        tick();
        chk("bp_y22", 32'(bus.y), 32'h22);
        chk("bp_ready_back", 32'(bus.in_ready), 1);
        tick();
        chk("bp_y33", 32'(bus.y), 32'h33);
        chk("bp_v33", 32'(bus.out_valid), 1);
        bus.in_valid = 1'b0;
        tick();
        chk("bp_empty", 32'(bus.out_valid), 0);
        chk("bp_cnt_sat", 32'(bus.chg_count), 3);

        // Change detect
        do_reset();
        bus.out_ready = 1'b1;
        drive(1'b1, OP_NOT, 8'h00);
        tick();
        chk("cd_nochg0", 32'(bus.y_changed), 0);
        drive(1'b1, OP_NOT, 8'h00);
        tick();
        chk("cd_chg1", 32'(bus.y_changed), 1);
        chk("cd_cnt1", 32'(bus.chg_count), 1);
        drive(1'b1, OP_BUF, 8'h00);
        tick();
        chk("cd_nochg2", 32'(bus.y_changed), 0);
        bus.in_valid = 1'b0;
        tick();
        chk("cd_chg3", 32'(bus.y_changed), 1);
        tick();
        chk("cd_pulse_end", 32'(bus.y_changed), 0);
        chk("cd_cnt2", 32'(bus.chg_count), 2);

        // Saturation and clear
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, OP_BUF, (i % 2 == 0) ? 8'hFF : 8'h00);
            tick();
        end
        bus.in_valid = 1'b0;
        tick();
        chk("sat_cnt3", 32'(bus.chg_count), 3);
        tick();
        chk("sat_hold", 32'(bus.chg_count), 3);
        drive(1'b1, OP_BUF, 8'h00);
        tick();
        bus.in_valid  = 1'b0;
        bus.clear_cnt = 1'b1;
        tick();
        chk("clr_with_chg", 32'(bus.chg_count), 1);
        tick();
        bus.clear_cnt = 1'b0;
        chk("clr_plain", 32'(bus.chg_count), 0);

        // Reset mid-operation with a full queue
        bus.out_ready = 1'b0;
        drive(1'b1, OP_BUF, 8'hAA);
        tick();
        drive(1'b1, OP_BUF, 8'h55);
        tick();
        bus.in_valid = 1'b0;
        chk("mid_full", 32'(bus.in_ready), 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_async_v", 32'(bus.out_valid), 0);
        chk("mid_async_y", 32'(bus.y), 0);
        chk("mid_async_rdy", 32'(bus.in_ready), 0);
        tick();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        chk("mid_no_stale", 32'(bus.out_valid), 0);
        drive(1'b1, OP_BUF, 8'h3C);
        tick();
        bus.in_valid = 1'b0;
        chk("mid_new_v", 32'(bus.out_valid), 1);
        chk("mid_new_y", 32'(bus.y), 32'h3C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
